rv_multicycle_ctrl: RTL

Control FSM that sequences the RV32I datapath (PC, IR, immediate generator, register file, ALU, data memory) over multiple cycles per instruction, replacing single-cycle combinational control. It drives a shared single-port memory through a req/ready handshake for both fetch and load/store. It decodes the IR opcode/funct fields and emits per-state datapath enables and mux selects. The immediate generator stays a pure combinational slave on the IR.

---
 rtl/rv_pkg.sv | 40 ++++
 rtl/rv_multicycle_ctrl_if.sv | 31 +++
 rtl/rv_ctrl_decode.sv | 28 ++
 rtl/rv_multicycle_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared encodings for the RV32I multicycle controller: opcodes, FSM states,
// instruction classes and datapath mux select codes.
package rv_pkg;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMem, StWb, StTrap
  } state_e;

  typedef enum logic [3:0] {
    ClsR, ClsImm, ClsLoad, ClsStore, ClsBranch, ClsJal, ClsJalr, ClsLui, ClsAuipc, ClsIllegal
  } cls_e;

  localparam logic [1:0] PcSelPc4 = 2'd0;
  localparam logic [1:0] PcSelAlu = 2'd1;
  localparam logic [1:0] PcSelImm = 2'd2;

  localparam logic [1:0] AluASrcRs1  = 2'd0;
  localparam logic [1:0] AluASrcPc   = 2'd1;
  localparam logic [1:0] AluASrcZero = 2'd2;

  localparam logic AluBSrcRs2 = 1'b0;
  localparam logic AluBSrcImm = 1'b1;

  localparam logic [1:0] WbSelAlu = 2'd0;
  localparam logic [1:0] WbSelMem = 2'd1;
  localparam logic [1:0] WbSelPc4 = 2'd2;

  localparam logic [3:0] AluAdd = 4'b0000;

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller side,
// slave = datapath and memory side.
interface rv_multicycle_ctrl_if;
  logic [31:0] inst;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic [1:0]  alu_src_a;
  logic        alu_src_b;
  logic [3:0]  alu_op;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        halted;

  modport master (
    input  inst, branch_taken, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
           alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, halted
  );

  modport slave (
    output inst, branch_taken, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
           alu_src_a, alu_src_b, alu_op, reg_we, wb_sel, halted
  );
endinterface

// File: rtl/rv_ctrl_decode.sv
// Combinational IR opcode -> instruction class, plus an illegal flag that the
// immediate generator's checks can share.
module rv_ctrl_decode
  import rv_pkg::*;
(
  input  logic [31:0] inst,
  output cls_e        cls,
  output logic        illegal
);

  always_comb begin
    cls = ClsIllegal;
    unique case (inst[6:0])
      OpR:      cls = ClsR;
      OpImm:    cls = ClsImm;
      OpLoad:   cls = ClsLoad;
      OpStore:  cls = ClsStore;
      OpBranch: cls = ClsBranch;
      OpJal:    cls = ClsJal;
      OpJalr:   cls = ClsJalr;
      OpLui:    cls = ClsLui;
      OpAuipc:  cls = ClsAuipc;
      default:  cls = ClsIllegal;
    endcase
    illegal = (cls == ClsIllegal);
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle RV32I control FSM with a memory-wait watchdog.
// Define RV_CTRL_PERF_CNT_EN to add cycle_cnt / instret_cnt performance counters.
module rv_multicycle_ctrl
  import rv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rv_multicycle_ctrl_if.master  bus
`ifdef RV_CTRL_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      instret_cnt
`endif
);

  localparam int unsigned WdW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(MEM_TIMEOUT - 1);

  state_e         state_q, state_d;
  logic           live_q;
  logic [WdW-1:0] wd_q, wd_d;
  cls_e           cls;
  logic           illegal;
  logic [1:0]     alu_a;
  logic           alu_b;
  logic [3:0]     alu_op;

  rv_ctrl_decode u_decode (
    .inst    (bus.inst),
    .cls     (cls),
    .illegal (illegal)
  );

  // ALU selects are held through MEM/WB because the ALU result is combinational.
  always_comb begin
    alu_a  = AluASrcRs1;
    alu_b  = AluBSrcRs2;
    alu_op = AluAdd;
    unique case (cls)
      ClsR:   alu_op = {bus.inst[30], bus.inst[14:12]};
      ClsImm: begin
        alu_b  = AluBSrcImm;
        alu_op = {(bus.inst[14:12] == 3'b101) & bus.inst[30], bus.inst[14:12]};
      end
      ClsLoad, ClsStore, ClsJalr: alu_b = AluBSrcImm;
      ClsLui: begin
        alu_a = AluASrcZero;
        alu_b = AluBSrcImm;
      end
      ClsAuipc: begin
        alu_a = AluASrcPc;
        alu_b = AluBSrcImm;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d          = state_q;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.pc_sel       = PcSelPc4;
    bus.alu_src_a    = AluASrcRs1;
    bus.alu_src_b    = AluBSrcRs2;
    bus.alu_op       = AluAdd;
    bus.reg_we       = 1'b0;
    bus.wb_sel       = WbSelAlu;
    bus.halted       = 1'b0;
    // The first cycle after reset is quiet so an abandoned request drops at once.
    if (live_q) begin
      unique case (state_q)
        StFetch: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_we = 1'b1;
            state_d   = StDecode;
          end
        end
        StDecode: state_d = illegal ? StTrap : StExec;
        StExec: begin
          bus.alu_src_a = alu_a;
          bus.alu_src_b = alu_b;
          bus.alu_op    = alu_op;
          unique case (cls)
            ClsR, ClsImm, ClsLui, ClsAuipc: state_d = StWb;
            ClsLoad, ClsStore:              state_d = StMem;
            ClsBranch: begin
              bus.pc_we  = 1'b1;
              bus.pc_sel = bus.branch_taken ? PcSelImm : PcSelPc4;
              state_d    = StFetch;
            end
            ClsJal: begin
              bus.pc_we  = 1'b1;
              bus.pc_sel = PcSelImm;
              state_d    = StWb;
            end
            ClsJalr: begin
              bus.pc_we  = 1'b1;
              bus.pc_sel = PcSelAlu;
              state_d    = StWb;
            end
            default: state_d = StTrap;
          endcase
        end
        StMem: begin
          bus.alu_src_a    = alu_a;
          bus.alu_src_b    = alu_b;
          bus.alu_op       = alu_op;
          bus.mem_req      = 1'b1;
          bus.mem_addr_sel = 1'b1;
          bus.mem_we       = (cls == ClsStore);
          if (bus.mem_ready) begin
            bus.pc_we = 1'b1;
            if (cls == ClsLoad) begin
              bus.reg_we = 1'b1;
              bus.wb_sel = WbSelMem;
            end
            state_d = StFetch;
          end
        end
        StWb: begin
          bus.alu_src_a = alu_a;
          bus.alu_src_b = alu_b;
          bus.alu_op    = alu_op;
          bus.reg_we    = 1'b1;
          if (cls == ClsJal || cls == ClsJalr) begin
            bus.wb_sel = WbSelPc4;
          end else begin
            bus.pc_we = 1'b1;
          end
          state_d = StFetch;
        end
        StTrap:  bus.halted = 1'b1;
        default: state_d = StTrap;
      endcase
    end

    if (MEM_TIMEOUT != 0 && bus.mem_req && !bus.mem_ready && wd_q == WdLast) begin
      state_d = StTrap;
    end

    if (MEM_TIMEOUT == 0 || !bus.mem_req || bus.mem_ready || state_d != state_q) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      live_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      wd_q    <= wd_d;
    end
  end

`ifdef RV_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      if (state_q != StTrap) cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (state_d == StFetch && (state_q == StExec || state_q == StMem || state_q == StWb)) begin
        instret_cnt_q <= instret_cnt_q + 1'b1;
      end
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule
